// File: rtl/zoom_nn_if.sv
// Handshake and memory-side bus of the nearest-neighbour scaler.
// master = control FSM / memories side, slave = scaler side.
interface zoom_nn_if #(
  parameter int PIX_W  = 8,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 21
);
  logic              start;
  logic [1:0]        zoom_select;
  logic              zoom_out;
  logic              abort;
  logic [PIX_W-1:0]  pixel_in;
  logic [SRC_AW-1:0] rom_addr;
  logic [DST_AW-1:0] ram_addr;
  logic [PIX_W-1:0]  pixel_out;
  logic              wren;
  logic              busy;
  logic              done;

  modport master (
    output start, zoom_select, zoom_out, abort, pixel_in,
    input  rom_addr, ram_addr, pixel_out, wren, busy, done
  );

  modport slave (
    input  start, zoom_select, zoom_out, abort, pixel_in,
    output rom_addr, ram_addr, pixel_out, wren, busy, done
  );
endinterface

// File: rtl/zoom_nn_scaler.sv
// Nearest-neighbour 1x/2x/4x/8x up/down scaler from source ROM to frame RAM.
// Optional feature macro: ZOOM_NN_ABORT_EN (frame cancel via abort).
module zoom_nn_scaler #(
  parameter int SRC_W   = 160,
  parameter int SRC_H   = 120,
  parameter int PIX_W   = 8,
  parameter int SRC_AW  = 15,
  parameter int DST_AW  = 21,
  parameter int ROM_LAT = 1
) (
  input logic      clk,
  input logic      rst_n,
  zoom_nn_if.slave bus
);

  localparam int XW = $clog2(SRC_W * 8 + 1);
  localparam int YW = $clog2(SRC_H * 8 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t            state;
  logic [1:0]        s_q;
  logic              zo_q;
  logic [XW-1:0]     x, ow;
  logic [YW-1:0]     y, oh;
  logic [2:0]        xr, yr, rep_max;
  logic [SRC_AW-1:0] rom_q, row_base, step_x, step_row;
  logic [DST_AW-1:0] cnt;
  logic [DST_AW-1:0] adr [1:ROM_LAT];
  logic [ROM_LAT:0]  vld;
  logic [DST_AW-1:0] ram_q;
  logic [PIX_W-1:0]  pix_q;
  logic              wren_q, busy_q, done_q;
  logic              last_x, last_y;

  function automatic logic [XW-1:0] dim_w(input logic [1:0] s, input logic zo);
    return zo ? XW'(SRC_W >> s) : XW'(SRC_W << s);
  endfunction

  function automatic logic [YW-1:0] dim_h(input logic [1:0] s, input logic zo);
    return zo ? YW'(SRC_H >> s) : YW'(SRC_H << s);
  endfunction

  always_comb begin
    ow       = dim_w(s_q, zo_q);
    oh       = dim_h(s_q, zo_q);
    rep_max  = 3'((4'd1 << s_q) - 4'd1);
    step_x   = zo_q ? SRC_AW'(1 << s_q) : SRC_AW'(1);
    step_row = zo_q ? SRC_AW'(SRC_W << s_q) : SRC_AW'(SRC_W);
    last_x   = (x == ow - XW'(1));
    last_y   = (y == oh - YW'(1));
  end

  assign bus.rom_addr  = rom_q;
  assign bus.ram_addr  = ram_q;
  assign bus.pixel_out = pix_q;
  assign bus.wren      = wren_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifndef ZOOM_NN_ABORT_EN
  logic abort_unused;
  assign abort_unused = bus.abort;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_q      <= '0;
      zo_q     <= 1'b0;
      x        <= '0;
      y        <= '0;
      xr       <= '0;
      yr       <= '0;
      rom_q    <= '0;
      row_base <= '0;
      cnt      <= '0;
      vld      <= '0;
      ram_q    <= '0;
      pix_q    <= '0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned j = 1; j <= ROM_LAT; j++) adr[j] <= '0;
    end else begin
      // Bit 0 is re-driven below when a pixel is issued this cycle.
      vld    <= {vld[ROM_LAT-1:0], 1'b0};
      adr[1] <= cnt;
      for (int unsigned j = 2; j <= ROM_LAT; j++) adr[j] <= adr[j-1];
      wren_q <= vld[ROM_LAT];
      if (vld[ROM_LAT]) begin
        ram_q <= adr[ROM_LAT];
        pix_q <= bus.pixel_in;
      end
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            s_q      <= bus.zoom_select;
            zo_q     <= bus.zoom_out;
            x        <= '0;
            y        <= '0;
            xr       <= '0;
            yr       <= '0;
            cnt      <= '0;
            rom_q    <= '0;
            row_base <= '0;
            busy_q   <= 1'b1;
            if (dim_w(bus.zoom_select, bus.zoom_out) == '0 ||
                dim_h(bus.zoom_select, bus.zoom_out) == '0) begin
              state <= DRAIN;
            end else begin
              state  <= RUN;
              vld[0] <= 1'b1;
            end
          end
        end

        RUN: begin
          if (last_x && last_y) begin
            state <= DRAIN;
          end else begin
            vld[0] <= 1'b1;
            cnt    <= cnt + DST_AW'(1);
            // Replication sub-counters stand in for x>>s / y>>s; in downscale every step advances.
            if (last_x) begin
              x  <= '0;
              xr <= '0;
              y  <= y + YW'(1);
              if (zo_q || yr == rep_max) begin
                yr       <= '0;
                row_base <= row_base + step_row;
                rom_q    <= row_base + step_row;
              end else begin
                yr    <= yr + 3'd1;
                rom_q <= row_base;
              end
            end else begin
              x <= x + XW'(1);
              if (zo_q || xr == rep_max) begin
                xr    <= '0;
                rom_q <= rom_q + step_x;
              end else begin
                xr <= xr + 3'd1;
              end
            end
          end
        end

        DRAIN: begin
          if (vld == '0) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase

`ifdef ZOOM_NN_ABORT_EN
      if (bus.abort && (state == RUN || state == DRAIN)) begin
        vld    <= '0;
        wren_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        state  <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_zoom_nn_scaler.sv
// Self-checking bench for zoom_nn_scaler: SRC_W=4, SRC_H=2, two DUTs with ROM_LAT=1 and 3.
// Table-driven frames, random frames against an arithmetic reference, and corner sequences.
module tb_zoom_nn_scaler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start3, abort, zout;
  logic [1:0] zsel;
  logic [7:0] rom [0:7];
  logic [7:0] rp1;
  logic [7:0] rp3 [0:2];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  zoom_nn_if #(.PIX_W(8), .SRC_AW(3), .DST_AW(9)) bus1 ();
  zoom_nn_if #(.PIX_W(8), .SRC_AW(3), .DST_AW(9)) bus3 ();

  assign bus1.start       = start1;
  assign bus1.zoom_select = zsel;
  assign bus1.zoom_out    = zout;
  assign bus1.abort       = abort;
  assign bus1.pixel_in    = rp1;
  assign bus3.start       = start3;
  assign bus3.zoom_select = zsel;
  assign bus3.zoom_out    = zout;
  assign bus3.abort       = abort;
  assign bus3.pixel_in    = rp3[2];

  zoom_nn_scaler #(.SRC_W(4), .SRC_H(2), .PIX_W(8), .SRC_AW(3), .DST_AW(9), .ROM_LAT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  zoom_nn_scaler #(.SRC_W(4), .SRC_H(2), .PIX_W(8), .SRC_AW(3), .DST_AW(9), .ROM_LAT(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Synchronous source ROMs with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    rp1    <= rom[bus1.rom_addr];
    rp3[0] <= rom[bus3.rom_addr];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: source pixel index of output pixel k from the scaling rules.
  function automatic int src_of(input int s, input int zo, input int k);
    int ow, x, y, xs, ys;
    ow = zo ? (4 >> s) : (4 << s);
    if (ow == 0 || k < 0) return 0;
    x  = k % ow;
    y  = k / ow;
    xs = zo ? (x << s) : (x >> s);
    ys = zo ? (y << s) : (y >> s);
    return (ys * 4 + xs) & 7;
  endfunction

  task automatic sample(input int sel, output logic [2:0] ra, output logic [8:0] wa,
                        output logic [7:0] po, output logic we, output logic bz, output logic dn);
    if (sel != 0) begin
      ra = bus3.rom_addr; wa = bus3.ram_addr; po = bus3.pixel_out;
      we = bus3.wren; bz = bus3.busy; dn = bus3.done;
    end else begin
      ra = bus1.rom_addr; wa = bus1.ram_addr; po = bus1.pixel_out;
      we = bus1.wren; bz = bus1.busy; dn = bus1.done;
    end
  endtask

  // Called at a negedge; start is asserted immediately. mode: 0 plain, 1 mid-frame
  // start + zoom change, 2 start in the done cycle, 3 abort held from cycle 5.
  task automatic run_frame(input int s, input int zo, input int sel, input int mode,
                           output int nw, output int donec, output int firstw);
    int L, ow, oh, n, dc, lb, k;
    logic [2:0] ra;
    logic [8:0] wa;
    logic [7:0] po;
    logic we, bz, dn;
    L  = (sel != 0) ? 3 : 1;
    ow = zo ? (4 >> s) : (4 << s);
    oh = zo ? (2 >> s) : (2 << s);
    n  = ow * oh;
    dc = (n == 0) ? 2 : n + L + 2;
    lb = (n == 0) ? 1 : n + L + 1;
    nw = 0; donec = 0; firstw = 0;
    zsel = 2'(s); zout = 1'(zo);
    if (sel != 0) start3 = 1'b1; else start1 = 1'b1;
    for (int cyc = 1; cyc <= dc + 4 && donec == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start1 = 1'b0; start3 = 1'b0; end
      sample(sel, ra, wa, po, we, bz, dn);
      if (cyc <= n) chk("rom_addr", 32'(ra), 32'(src_of(s, zo, cyc - 1)));
      chk("busy", 32'(bz), 32'(cyc <= lb));
      chk("done", 32'(dn), 32'(cyc == dc));
      chk("wren", 32'(we), 32'(cyc >= L + 2 && cyc <= n + L + 1));
      if (we) begin
        k = cyc - L - 2;
        if (firstw == 0) firstw = cyc;
        chk("ram_addr", 32'(wa), 32'(k));
        chk("pixel_out", 32'(po), 32'(rom[src_of(s, zo, k)]));
        nw++;
      end
      if (dn) donec = cyc;
      if (mode == 1 && cyc == 3) begin
        zsel = ~zsel; zout = ~zout;
        if (sel != 0) start3 = 1'b1; else start1 = 1'b1;
      end
      if (mode == 1 && cyc == 4) begin start1 = 1'b0; start3 = 1'b0; end
      if (mode == 3 && cyc == 5) abort = 1'b1;
    end
    if (donec == 0) chk("done_timeout", 32'd0, 32'd1);
    chk("write_count", 32'(nw), 32'(n));
    if (mode == 2) begin
      if (sel != 0) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      sample(sel, ra, wa, po, we, bz, dn);
      chk("b2b_start_ignored", 32'(bz), 32'd0);
    end
    abort = 1'b0;
  endtask

  typedef struct {
    int s; int zo; int sel; int mode;
    int n; int dc; int fw;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int nw, dc, fw;
    int rs, rzo, rsel;
    logic stray;

    tbl[0] = '{0, 0, 0, 0,   8,  11, 3};
    tbl[1] = '{1, 0, 0, 1,  32,  35, 3};
    tbl[2] = '{1, 1, 0, 0,   2,   5, 3};
    tbl[3] = '{3, 1, 0, 2,   0,   2, 0};
    tbl[4] = '{0, 0, 1, 0,   8,  13, 5};
    tbl[5] = '{2, 1, 1, 0,   0,   2, 0};
    tbl[6] = '{2, 0, 0, 2, 128, 131, 3};
    tbl[7] = '{3, 0, 1, 0, 512, 517, 5};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; zsel = '0; zout = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_vals_lat1", 32'({bus1.rom_addr, bus1.ram_addr, bus1.pixel_out,
                                bus1.wren, bus1.busy, bus1.done}), 32'd0);
    chk("reset_vals_lat3", 32'({bus3.rom_addr, bus3.ram_addr, bus3.pixel_out,
                                bus3.wren, bus3.busy, bus3.done}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_frame(tbl[i].s, tbl[i].zo, tbl[i].sel, tbl[i].mode, nw, dc, fw);
      chk("tbl_writes", 32'(nw), 32'(tbl[i].n));
      chk("tbl_done_cycle", 32'(dc), 32'(tbl[i].dc));
      chk("tbl_first_wren", 32'(fw), 32'(tbl[i].fw));
    end

    for (int i = 0; i < 12; i++) begin
      rs   = int'($urandom_range(0, 3));
      rzo  = int'($urandom_range(0, 1));
      rsel = int'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) rom[j] = 8'($urandom);
      @(negedge clk);
      run_frame(rs, rzo, rsel, 0, nw, dc, fw);
    end

    // Mid-frame asynchronous reset on a 2x frame.
    @(negedge clk);
    zsel = 2'd1; zout = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_frame_writing", 32'(bus1.wren), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_vals", 32'({bus1.rom_addr, bus1.ram_addr, bus1.pixel_out,
                                     bus1.wren, bus1.busy, bus1.done}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.wren || bus1.busy || bus1.done) stray = 1'b1;
    end
    chk("quiet_after_reset", 32'(stray), 32'd0);
    @(negedge clk);
    run_frame(0, 0, 0, 0, nw, dc, fw);

`ifdef ZOOM_NN_ABORT_EN
    @(negedge clk);
    zsel = 2'd1; zout = 1'b0; start1 = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      chk("abort_no_done", 32'(bus1.done), 32'd0);
      if (cyc == 5) abort = 1'b1;
      if (cyc == 6) begin
        abort = 1'b0;
        chk("abort_wren_low", 32'(bus1.wren), 32'd0);
        chk("abort_busy_low", 32'(bus1.busy), 32'd0);
      end
    end
    run_frame(1, 0, 0, 0, nw, dc, fw);
`else
    @(negedge clk);
    run_frame(1, 0, 0, 3, nw, dc, fw);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
